mvm_feeder: RTL

MVM_FEEDER -- requirements
Module: mvm_feeder

---
 rtl/mvm_feeder.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mvm_feeder.sv
// mvm_feeder: buffers one matrix-vector job from a valid/ready stream and
// replays it to a downstream MVM engine as a matrix burst, a vector burst and
// a start pulse.
//
// Ports
//   clk, reset             : clock, synchronous active-high reset
//   s_valid/s_ready/s_data : upstream word stream (matrix row-major, then vector)
//   s_vec_only             : sampled on a job's first word; 1 = K vector words only
//   loadMatrix/loadVector  : one-cycle pulses opening a downstream burst
//   start                  : one-cycle pulse launching downstream computation
//   data_in                : burst data, zero outside burst data cycles
//   done                   : downstream completion pulse
//   mvm_busy               : start issued, matching done not yet seen
module mvm_feeder #(
    parameter int K = 32,
    parameter int B = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic signed [B-1:0] s_data,
    input  logic                s_vec_only,
    output logic                loadMatrix,
    output logic                loadVector,
    output logic                start,
    output logic signed [B-1:0] data_in,
    input  logic                done,
    output logic                mvm_busy
);

    localparam int MW    = K * K;
    localparam int DEPTH = K * K + K;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [2:0] {FILL, WAIT, SEND_M, SEND_V, START} state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] wr_cnt_reg, wr_cnt_next;
    logic [AW-1:0] rd_cnt_reg, rd_cnt_next;
    logic          job_vec_reg, job_vec_next;
    logic          mat_valid_reg, mat_valid_next;
    logic          busy_reg, busy_next;

    logic [B-1:0]  mem [0:DEPTH-1];
    logic [B-1:0]  rd_data_reg;
    logic          rd_valid_reg;
    logic          rd_zero_reg;

    logic          cur_vec;
    logic [AW-1:0] job_last;
    logic [AW-1:0] wr_addr;
    logic          accept;
    logic          rd_en;
    logic          rd_zero;
    logic [AW-1:0] rd_addr;
    logic          ready_c, lm_c, lv_c, st_c;

    // The job type is taken from the first word only; later words keep the
    // latched value.
    assign cur_vec  = (wr_cnt_reg == '0) ? s_vec_only : job_vec_reg;
    assign job_last = cur_vec ? AW'(K - 1) : AW'(DEPTH - 1);
    assign wr_addr  = cur_vec ? (AW'(MW) + wr_cnt_reg) : wr_cnt_reg;
    assign accept   = s_valid && (state_reg == FILL) && !reset;

    always_comb begin
        state_next     = state_reg;
        wr_cnt_next    = wr_cnt_reg;
        rd_cnt_next    = rd_cnt_reg;
        job_vec_next   = job_vec_reg;
        mat_valid_next = mat_valid_reg;
        rd_en          = 1'b0;
        rd_zero        = 1'b0;
        rd_addr        = '0;
        ready_c        = 1'b0;
        lm_c           = 1'b0;
        lv_c           = 1'b0;
        st_c           = 1'b0;

        case (state_reg)
            FILL: begin
                ready_c = 1'b1;
                if (s_valid) begin
                    job_vec_next = cur_vec;
                    if (wr_cnt_reg == job_last) begin
                        wr_cnt_next = '0;
                        state_next  = WAIT;
                        if (!cur_vec) begin
                            mat_valid_next = 1'b1;
                        end
                    end else begin
                        wr_cnt_next = wr_cnt_reg + 1'b1;
                    end
                end
            end
            WAIT: begin
                // A vec_only job without a retained matrix still sends the
                // matrix burst, but with zero data.
                if (!busy_reg) begin
                    state_next = (job_vec_reg && mat_valid_reg) ? SEND_V : SEND_M;
                end
            end
            SEND_M: begin
                // Reads are issued on counts 0..MW-1 so each word appears on
                // data_in one cycle later; count MW is the drain cycle.
                lm_c = (rd_cnt_reg == '0);
                if (rd_cnt_reg != AW'(MW)) begin
                    rd_en       = 1'b1;
                    rd_zero     = !mat_valid_reg;
                    rd_addr     = rd_cnt_reg;
                    rd_cnt_next = rd_cnt_reg + 1'b1;
                end else begin
                    rd_cnt_next = '0;
                    state_next  = SEND_V;
                end
            end
            SEND_V: begin
                lv_c = (rd_cnt_reg == '0);
                if (rd_cnt_reg != AW'(K)) begin
                    rd_en       = 1'b1;
                    rd_addr     = AW'(MW) + rd_cnt_reg;
                    rd_cnt_next = rd_cnt_reg + 1'b1;
                end else begin
                    rd_cnt_next = '0;
                    state_next  = START;
                end
            end
            START: begin
                st_c       = 1'b1;
                state_next = FILL;
            end
            default: begin
                state_next = FILL;
            end
        endcase

        // start has priority over a coincident done.
        if (st_c) begin
            busy_next = 1'b1;
        end else if (done) begin
            busy_next = 1'b0;
        end else begin
            busy_next = busy_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= FILL;
            wr_cnt_reg    <= '0;
            rd_cnt_reg    <= '0;
            job_vec_reg   <= 1'b0;
            mat_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            rd_valid_reg  <= 1'b0;
            rd_zero_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_cnt_reg    <= wr_cnt_next;
            rd_cnt_reg    <= rd_cnt_next;
            job_vec_reg   <= job_vec_next;
            mat_valid_reg <= mat_valid_next;
            busy_reg      <= busy_next;
            rd_valid_reg  <= rd_en;
            rd_zero_reg   <= rd_zero;
        end
    end

    // Buffer with registered read; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_addr] <= s_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    // Outputs are forced quiet while reset is held, even mid-burst.
    assign s_ready    = ready_c && !reset;
    assign loadMatrix = lm_c && !reset;
    assign loadVector = lv_c && !reset;
    assign start      = st_c && !reset;
    assign data_in    = (rd_valid_reg && !rd_zero_reg && !reset) ? rd_data_reg : '0;
    assign mvm_busy   = busy_reg;

endmodule
